// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and constants for the fetch stage
package pipe_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_FULL
  } fetch_state_t;

  typedef enum logic [2:0] {
    OTHERS = 3'd0,
    BEQ    = 3'd1,
    BNE    = 3'd2,
    JR     = 3'd3,
    J      = 3'd4,
    JAL    = 3'd7
  } jump_branch_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {valid, pc, instr} holding buffer for a stalled fetch response
module fetch_skid_buf
  import pipe_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               drain,
  input  logic               flush,
  input  logic [31:0]        load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               buf_valid,
  output logic [31:0]        buf_pc,
  output logic [INSTR_W-1:0] buf_instr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_instr <= NOP_INSTR;
    end else if (flush || drain) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_pc    <= load_pc;
      buf_instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, imem request/response, IF/ID register; FETCH_PERF_EN adds perf counters
module fetch_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_stall,
  input  logic               id_stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  output logic [INSTR_W-1:0] id_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  // Redirect target parked while DRAIN keeps presenting the wrong-path address in pc_q.
  logic [31:0]  tgt_q, tgt_d;

  logic wr_instr, wr_buf, wr_bubble;
  logic skid_load, skid_drain, skid_flush;
  logic               buf_valid;
  logic [31:0]        buf_pc;
  logic [INSTR_W-1:0] buf_instr;

  logic acc_redirect;
  assign acc_redirect = redirect_valid && !id_stall;

  assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign imem_addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    wr_instr   = 1'b0;
    wr_buf     = 1'b0;
    wr_bubble  = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d   = ST_FETCH;
        wr_bubble = !id_stall;
        if (acc_redirect) pc_d = redirect_pc;
      end
      ST_FETCH: begin
        if (acc_redirect) begin
          wr_bubble = 1'b1;
          if (imem_valid) begin
            pc_d = redirect_pc;
          end else begin
            tgt_d   = redirect_pc;
            state_d = ST_DRAIN;
          end
        end else if (imem_valid) begin
          if (!if_stall) begin
            wr_instr = 1'b1;
            pc_d     = pc_q + PC_STEP;
          end else begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end
        end else begin
          wr_bubble = !id_stall;
        end
      end
      ST_DRAIN: begin
        wr_bubble = !id_stall;
        if (imem_valid) begin
          state_d = ST_FETCH;
          pc_d    = acc_redirect ? redirect_pc : tgt_q;
        end else if (acc_redirect) begin
          tgt_d = redirect_pc;
        end
      end
      ST_FULL: begin
        if (acc_redirect) begin
          skid_flush = 1'b1;
          wr_bubble  = 1'b1;
          pc_d       = redirect_pc;
          state_d    = ST_FETCH;
        end else if (!if_stall) begin
          wr_buf     = 1'b1;
          skid_drain = 1'b1;
          pc_d       = pc_q + PC_STEP;
          state_d    = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .drain      (skid_drain),
    .flush      (skid_flush),
    .load_pc    (pc_q),
    .load_instr (imem_rdata),
    .buf_valid  (buf_valid),
    .buf_pc     (buf_pc),
    .buf_instr  (buf_instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_pc4   <= '0;
      id_instr <= NOP_INSTR;
    end else if (wr_instr) begin
      id_valid <= 1'b1;
      id_pc    <= pc_q;
      id_pc4   <= pc_q + PC_STEP;
      id_instr <= imem_rdata;
    end else if (wr_buf) begin
      id_valid <= buf_valid;
      id_pc    <= buf_pc;
      id_pc4   <= buf_pc + PC_STEP;
      id_instr <= buf_instr;
    end else if (wr_bubble) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_pc4   <= '0;
      id_instr <= NOP_INSTR;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (wr_instr || wr_buf) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (wr_bubble) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a variable-latency instruction memory
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        if_stall;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int wait_cnt;
  logic mem_on;
  logic held;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .if_stall       (if_stall),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4),
    .id_instr       (id_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return addr ^ 32'hDEAD_0000;
  endfunction

  // Memory answers a request after it has been presented for lat cycles.
  assign imem_valid = mem_on && imem_req && (wait_cnt >= lat - 1);
  assign imem_rdata = instr_of(imem_addr);

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (!imem_req || imem_valid) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) held <= id_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (id_valid && !held) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_instr: got pc %h expected none", id_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("id_pc", id_pc, mon_e);
          check("id_pc4", id_pc4, mon_e + 32'd4);
          check("id_instr", id_instr, instr_of(mon_e));
        end
      end else if (!id_valid) begin
        check("bubble_instr", id_instr, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    if_stall = 1'b0;
    id_stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mem_on = 1'b1;
    lat = l;
    #1;
    check("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_pc4", id_pc4, 32'h0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    check("rst_perf_bubble", perf_bubble_cnt, 32'h0);
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic finish_test();
    mem_on = 1'b0;
    tick();
    tick();
    tick();
    check("queue_empty", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    if_stall = 1'b0;
    id_stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mem_on = 1'b0;
    tick();

    // 1-cycle memory streams one instruction per cycle from RESET_PC.
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset(1);
    tick();
    check("t1_req", {31'b0, imem_req}, 32'h1);
    check("t1_first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_back_to_back", {31'b0, id_valid}, 32'h1);
    end
    finish_test();

    // 3-cycle memory, then redirect to 0x100 with PC 12 outstanding.
    exp_q = '{32'h0, 32'h4, 32'h8, 32'h100};
    do_reset(3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_addr0_stable", imem_addr, 32'h0);
    end
    tick();
    check("t2_addr4", imem_addr, 32'h4);
    tick();
    check("t2_bubble1", {31'b0, id_valid}, 32'h0);
    tick();
    check("t2_bubble2", {31'b0, id_valid}, 32'h0);
    tick();
    tick();
    tick();
    tick();
    check("t2_addr12", imem_addr, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("t2_redir_bubble", {31'b0, id_valid}, 32'h0);
    check("t2_drain_addr", imem_addr, 32'hC);
    tick();
    check("t2_drain_addr2", imem_addr, 32'hC);
    tick();
    check("t2_target_addr", imem_addr, 32'h100);
    tick();
    tick();
    tick();
    tick();
    finish_test();

    // Stall in the cycle PC 8 returns, held two cycles.
    exp_q = '{32'h0, 32'h4, 32'h8};
    do_reset(1);
    tick();
    tick();
    tick();
    if_stall = 1'b1;
    id_stall = 1'b1;
    tick();
    check("t3_full_no_req", {31'b0, imem_req}, 32'h0);
    check("t3_hold_pc", id_pc, 32'h4);
    check("t3_hold_valid", {31'b0, id_valid}, 32'h1);
    tick();
    if_stall = 1'b0;
    id_stall = 1'b0;
    check("t3_full_no_req2", {31'b0, imem_req}, 32'h0);
    check("t3_hold_pc2", id_pc, 32'h4);
    tick();
    check("t3_release_pc", id_pc, 32'h8);
    check("t3_release_req", {31'b0, imem_req}, 32'h1);
    check("t3_release_addr", imem_addr, 32'hC);
    finish_test();

    // Redirect under stall is ignored; then redirect with response in hand, across PC wrap.
    exp_q = '{32'h0, 32'h4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    do_reset(1);
    tick();
    tick();
    if_stall = 1'b1;
    id_stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    if_stall = 1'b0;
    id_stall = 1'b0;
    redirect_valid = 1'b0;
    check("t4_stall_hold_pc", id_pc, 32'h0);
    check("t4_stall_hold_valid", {31'b0, id_valid}, 32'h1);
    check("t4_stall_no_req", {31'b0, imem_req}, 32'h0);
    tick();
    check("t4_no_redirect_addr", imem_addr, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    check("t4_redir_bubble", {31'b0, id_valid}, 32'h0);
    check("t4_target_addr", imem_addr, 32'hFFFF_FFF8);
    tick();
    tick();
    tick();
    finish_test();

    // Reset asserted while draining a wrong-path request.
    exp_q = '{32'h0, 32'h0};
    do_reset(3);
    tick();
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    check("t5_drain_req", {31'b0, imem_req}, 32'h1);
    check("t5_drain_addr", imem_addr, 32'h4);
    check("t5_drain_bubble", {31'b0, id_valid}, 32'h0);
`ifdef FETCH_PERF_EN
    check("t5_perf_fetch", perf_fetch_cnt, 32'd1);
    check("t5_perf_bubble", perf_bubble_cnt, 32'd4);
`endif
    do_reset(3);
    tick();
    check("t5_restart_req", {31'b0, imem_req}, 32'h1);
    check("t5_restart_addr", imem_addr, 32'h0);
    tick();
    tick();
    tick();
    finish_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
